// File: rtl/button_word_loader.sv
// Serial-to-parallel word assembler for button entry.
// Each enable pulse shifts one data-button bit into a partial word. A completed
// word is held on word_o with valid_o until the downstream loader accepts it.
module button_word_loader #(
  parameter int unsigned WIDTH_P     = 8,
  parameter bit          MSB_FIRST_P = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         bit_valid_i,
  input  logic                         bit_i,
  input  logic                         clear_i,
  output logic [WIDTH_P-1:0]           word_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WIDTH_P-1:0]           partial_o,
  output logic [$clog2(WIDTH_P+1)-1:0] count_o,
  output logic                         overrun_o
);

  localparam int unsigned CountW = $clog2(WIDTH_P + 1);
  localparam logic [CountW-1:0] LastCount = CountW'(WIDTH_P - 1);

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  state_e              state_q;
  logic [WIDTH_P-1:0]  partial_q;
  logic [WIDTH_P-1:0]  word_q;
  logic [CountW-1:0]   count_q;
  logic                valid_q;
  logic                overrun_q;
  logic [WIDTH_P-1:0]  shifted;

  // Partial word with the incoming bit shifted in, in the configured bit order.
  always_comb begin
    shifted = partial_q;
    if (MSB_FIRST_P) begin
      shifted = {partial_q[WIDTH_P-2:0], bit_i};
    end else begin
      shifted = {bit_i, partial_q[WIDTH_P-1:1]};
    end
  end

  // Collect/full state machine with all outputs registered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StCollect;
      partial_q <= '0;
      word_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (clear_i) begin
      // word_q is kept so the display still shows the last accepted word.
      state_q   <= StCollect;
      partial_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (bit_valid_i) begin
            if (count_q == LastCount) begin
              word_q    <= shifted;
              valid_q   <= 1'b1;
              partial_q <= '0;
              count_q   <= '0;
              state_q   <= StFull;
            end else begin
              partial_q <= shifted;
              count_q   <= count_q + CountW'(1);
            end
          end
        end
        StFull: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= StCollect;
            // A bit arriving with the handshake starts the next word.
            if (bit_valid_i) begin
              partial_q <= shifted;
              count_q   <= CountW'(1);
            end
          end else if (bit_valid_i) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign word_o    = word_q;
  assign valid_o   = valid_q;
  assign partial_o = partial_q;
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_button_word_loader.sv
// Directed table-driven bench for button_word_loader, MSB-first and LSB-first builds.
module tb_button_word_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_valid, bit_in, clear, ready;
  logic [7:0] word, partial, lsb_word, lsb_partial;
  logic       valid, overrun, lsb_valid, lsb_overrun;
  logic [3:0] count, lsb_count;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  button_word_loader #(.WIDTH_P(8), .MSB_FIRST_P(1'b1)) u_msb (
    .clk_i(clk), .reset_n_i(reset_n), .bit_valid_i(bit_valid), .bit_i(bit_in),
    .clear_i(clear), .word_o(word), .valid_o(valid), .ready_i(ready),
    .partial_o(partial), .count_o(count), .overrun_o(overrun)
  );

  button_word_loader #(.WIDTH_P(8), .MSB_FIRST_P(1'b0)) u_lsb (
    .clk_i(clk), .reset_n_i(reset_n), .bit_valid_i(bit_valid), .bit_i(bit_in),
    .clear_i(clear), .word_o(lsb_word), .valid_o(lsb_valid), .ready_i(ready),
    .partial_o(lsb_partial), .count_o(lsb_count), .overrun_o(lsb_overrun)
  );

  typedef struct {
    logic       bv, b, rdy, clr;
    logic [7:0] word, part, lsb;
    logic       vld, ov;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic bv, input logic b, input logic rdy, input logic clr,
                     input logic [7:0] w, input logic v, input logic [7:0] p,
                     input logic [3:0] c, input logic o, input logic [7:0] l);
    vec_t r;
    r.bv = bv; r.b = b; r.rdy = rdy; r.clr = clr;
    r.word = w; r.vld = v; r.part = p; r.cnt = c; r.ov = o; r.lsb = l;
    vecs.push_back(r);
  endtask

  // Enter bits 1,0,1,1,0,0,1,0 with ready low; completes as B2 / 4D.
  task automatic add_fill(input logic [7:0] w_before, input logic [7:0] l_before);
    add(1, 1, 0, 0, w_before, 0, 8'h01, 1, 0, l_before);
    add(1, 0, 0, 0, w_before, 0, 8'h02, 2, 0, l_before);
    add(1, 1, 0, 0, w_before, 0, 8'h05, 3, 0, l_before);
    add(1, 1, 0, 0, w_before, 0, 8'h0B, 4, 0, l_before);
    add(1, 0, 0, 0, w_before, 0, 8'h16, 5, 0, l_before);
    add(1, 0, 0, 0, w_before, 0, 8'h2C, 6, 0, l_before);
    add(1, 1, 0, 0, w_before, 0, 8'h59, 7, 0, l_before);
    add(1, 0, 0, 0, 8'hB2,    1, 8'h00, 0, 0, 8'h4D);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] model;

    reset_n = 1'b0; bit_valid = 0; bit_in = 0; clear = 0; ready = 0;
    cycle();
    check("rst_word",    32'(word),    0);
    check("rst_valid",   32'(valid),   0);
    check("rst_partial", 32'(partial), 0);
    check("rst_count",   32'(count),   0);
    check("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    cycle();

    // Build the vector table.
    add_fill(8'h00, 8'h00);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 8'hB2, 1, 8'h00, 0, 0, 8'h4D);
    add(0, 0, 1, 0, 8'hB2, 0, 8'h00, 0, 0, 8'h4D);  // handshake
    add(0, 0, 1, 0, 8'hB2, 0, 8'h00, 0, 0, 8'h4D);  // ready with valid low ignored
    add_fill(8'hB2, 8'h4D);
    add(1, 1, 0, 0, 8'hB2, 1, 8'h00, 0, 1, 8'h4D);  // overrun, bit dropped
    add(0, 0, 0, 0, 8'hB2, 1, 8'h00, 0, 1, 8'h4D);  // sticky
    add(1, 1, 0, 1, 8'hB2, 0, 8'h00, 0, 0, 8'h4D);  // clear beats bit_valid
    add_fill(8'hB2, 8'h4D);
    add(1, 1, 1, 0, 8'hB2, 0, 8'h01, 1, 0, 8'h4D);  // bit with handshake
    add(1, 0, 0, 0, 8'hB2, 0, 8'h02, 2, 0, 8'h4D);
    add(1, 1, 0, 0, 8'hB2, 0, 8'h05, 3, 0, 8'h4D);
    add(1, 1, 0, 0, 8'hB2, 0, 8'h0B, 4, 0, 8'h4D);
    add(1, 0, 0, 0, 8'hB2, 0, 8'h16, 5, 0, 8'h4D);

    foreach (vecs[i]) begin
      bit_valid = vecs[i].bv; bit_in = vecs[i].b; ready = vecs[i].rdy; clear = vecs[i].clr;
      cycle();
      check($sformatf("v%0d_word", i),    32'(word),     32'(vecs[i].word));
      check($sformatf("v%0d_valid", i),   32'(valid),    32'(vecs[i].vld));
      check($sformatf("v%0d_partial", i), 32'(partial),  32'(vecs[i].part));
      check($sformatf("v%0d_count", i),   32'(count),    32'(vecs[i].cnt));
      check($sformatf("v%0d_overrun", i), 32'(overrun),  32'(vecs[i].ov));
      check($sformatf("v%0d_lsb_word", i), 32'(lsb_word), 32'(vecs[i].lsb));
    end
    bit_valid = 0; bit_in = 0; ready = 0; clear = 0;

    // Asynchronous reset in the middle of a clock period, five bits in.
    #3 reset_n = 1'b0;
    #1;
    check("arst_partial", 32'(partial), 0);
    check("arst_count",   32'(count),   0);
    check("arst_valid",   32'(valid),   0);
    check("arst_word",    32'(word),    0);
    check("arst_lsb",     32'(lsb_word), 0);
    cycle();
    check("arst_hold_count", 32'(count), 0);
    reset_n = 1'b1;
    cycle();

    // Fresh word A7 after reset; LSB-first build sees the bit reversal E5.
    pat = 8'hA7;
    model = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in = pat[7-i];
      model = {model[6:0], pat[7-i]};
      cycle();
      if (i < 7) begin
        check($sformatf("post_partial%0d", i), 32'(partial), 32'(model));
        check($sformatf("post_count%0d", i),   32'(count),   32'(i + 1));
        check($sformatf("post_valid%0d", i),   32'(valid),   0);
      end
    end
    bit_valid = 1'b0;
    check("post_word",     32'(word),     32'h0A7);
    check("post_lsb_word", 32'(lsb_word), 32'h0E5);
    check("post_valid",    32'(valid),    1);
    check("post_count",    32'(count),    0);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("post_hs_valid", 32'(valid), 0);
    check("post_hs_word",  32'(word),  32'h0A7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
